// File: rtl/agc_datapath.sv
// agc_datapath: ones'-complement register/ALU datapath driven by the control-pulse
// sequencer. Holds A,B,G,LP,Q,X,Y,Z. The ALU works combinationally on X and Y.
// Every register write in a cycle samples the pre-edge register values. B is
// decoded back into opcode/qc for the sequencer.
module agc_datapath #(
    parameter int                DATA_W    = 15,
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] RESET_VEC = 12'h800
) (
    input  logic              clk,
    input  logic              rst_n,
    // register / memory write strobes
    input  logic              mem_wr,
    input  logic              lp_wr,
    input  logic              g_wr,
    input  logic              q_wr,
    input  logic              b_wr,
    input  logic              a_wr,
    input  logic              y_wr,
    input  logic              x_wr,
    input  logic              z_wr,
    // source selects
    input  logic              maddr_mux,
    input  logic              mdata_mux,
    input  logic              lp_mux,
    input  logic              g_mux,
    input  logic              b_mux,
    input  logic [1:0]        q_mux,
    input  logic [1:0]        a_mux,
    input  logic [1:0]        x_mux,
    input  logic [1:0]        z_mux,
    input  logic [2:0]        alu_op,
    input  logic [2:0]        y_mux,
    input  logic              ext_flag,
    // memory interface
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    // decode back to the sequencer
    output logic [2:0]        opcode,
    output logic [1:0]        qc,
    output logic              extracode,
    // observation
    output logic [DATA_W-1:0] a_q,
    output logic [DATA_W-1:0] z_q,
    output logic              ovf
);

    localparam int DW2 = 2 * DATA_W;

    localparam logic [2:0] ALU_AD   = 3'd0;
    localparam logic [2:0] ALU_SU   = 3'd1;
    localparam logic [2:0] ALU_MASK = 3'd2;
    localparam logic [2:0] ALU_MP0  = 3'd3;
    localparam logic [2:0] ALU_MP1  = 3'd4;
    localparam logic [2:0] ALU_DV0  = 3'd5;
    localparam logic [2:0] ALU_DV1  = 3'd6;

    // Magnitude of a ones'-complement word (both zeros map to +0).
    function automatic logic [DATA_W-1:0] oc_mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? ~v : v;
    endfunction

    // Ones'-complement add with end-around carry; MSB of the return is overflow
    // (operand signs agree but the result sign differs).
    function automatic logic [DATA_W:0] oc_add(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        logic [DATA_W:0]   s;
        logic [DATA_W-1:0] r;
        logic              ov;
        s  = {1'b0, a} + {1'b0, b};
        r  = s[DATA_W-1:0] + {{(DATA_W-1){1'b0}}, s[DATA_W]};
        ov = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
        return {ov, r};
    endfunction

    // Branch offset selected by the sign class of a word: >+0, +0, <-0, -0.
    function automatic logic [DATA_W-1:0] ccs_offset(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (v == '0)
            r = DATA_W'(1);
        else if (v == '1)
            r = DATA_W'(3);
        else if (v[DATA_W-1])
            r = DATA_W'(2);
        else
            r = '0;
        return r;
    endfunction

    // |v| - 1, floored at +0 so that either zero yields +0.
    function automatic logic [DATA_W-1:0] mag_minus_one(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] m;
        m = oc_mag(v);
        return (m == '0) ? '0 : m - DATA_W'(1);
    endfunction

    logic [DATA_W-1:0] b_q, g_q, lp_q, q_q, x_q, y_q;
    logic [DATA_W-1:0] a_d, b_d, g_d, lp_d, q_d, x_d, y_d, z_d;
    logic              ext_q;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;
    logic [DATA_W:0]   add_r, sub_r;
    logic [DATA_W-1:0] mag_x, mag_y;
    logic [DW2-1:0]    prod;
    logic              prod_neg;
    logic [DATA_W-1:0] div_q, div_r;
    logic [DATA_W-1:0] y_src;
    logic [DATA_W-1:0] b_addr_ext;

    assign add_r      = oc_add(x_q, y_q);
    assign sub_r      = oc_add(x_q, ~y_q);
    assign mag_x      = oc_mag(x_q);
    assign mag_y      = oc_mag(y_q);
    assign prod       = DW2'(mag_x) * DW2'(mag_y);
    assign prod_neg   = x_q[DATA_W-1] ^ y_q[DATA_W-1];
    assign b_addr_ext = {{(DATA_W-ADDR_W){1'b0}}, b_q[ADDR_W-1:0]};

    // Unsigned magnitude divide; a zero divisor saturates the quotient magnitude
    // and passes the dividend magnitude through as remainder.
    always_comb begin
        div_q = {1'b0, {(DATA_W-1){1'b1}}};
        div_r = mag_x;
        if (mag_y != '0) begin
            div_q = mag_x / mag_y;
            div_r = mag_x % mag_y;
        end
    end

    // ALU function select; overflow is only meaningful for add/subtract.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_op)
            ALU_AD: begin
                alu_res = add_r[DATA_W-1:0];
                alu_ovf = add_r[DATA_W];
            end
            ALU_SU: begin
                alu_res = sub_r[DATA_W-1:0];
                alu_ovf = sub_r[DATA_W];
            end
            ALU_MASK: alu_res = x_q & y_q;
            ALU_MP0:  alu_res = prod_neg ? ~prod[DATA_W-1:0]   : prod[DATA_W-1:0];
            ALU_MP1:  alu_res = prod_neg ? ~prod[DW2-1:DATA_W] : prod[DW2-1:DATA_W];
            ALU_DV0:  alu_res = div_r;
            ALU_DV1:  alu_res = div_q;
            default:  alu_res = '0;
        endcase
    end

    // Y operand source select.
    always_comb begin
        y_src = '0;
        case (y_mux)
            3'd1:    y_src = mem_rdata;
            3'd2:    y_src = DATA_W'(1);
            3'd3:    y_src = ccs_offset(mem_rdata);
            3'd4:    y_src = mag_minus_one(mem_rdata);
            default: y_src = '0;
        endcase
    end

    // Next-state for every register; all sources read the current (pre-edge) values.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        g_d   = g_q;
        lp_d  = lp_q;
        q_d   = q_q;
        x_d   = x_q;
        y_d   = y_q;
        z_d   = z_q;
        ovf_d = ovf_q;

        if (a_wr) begin
            case (a_mux)
                2'd0: a_d = mem_rdata;
                2'd1: a_d = alu_res;
                2'd2: a_d = ~g_q;
                2'd3: a_d = g_q;
            endcase
        end
        if (b_wr)  b_d  = b_mux  ? alu_res : mem_rdata;
        if (g_wr)  g_d  = g_mux  ? alu_res : mem_rdata;
        if (lp_wr) lp_d = lp_mux ? alu_res : '0;
        if (q_wr) begin
            case (q_mux)
                2'd0: q_d = a_q;
                2'd1: q_d = alu_res;
                2'd2: q_d = z_q;
                2'd3: q_d = mem_rdata;
            endcase
        end
        if (z_wr) begin
            case (z_mux)
                2'd0: z_d = mem_rdata;
                2'd1: z_d = alu_res;
                2'd2: z_d = b_addr_ext;
                2'd3: z_d = a_q;
            endcase
        end
        if (x_wr) begin
            case (x_mux)
                2'd0: x_d = a_q;
                2'd1: x_d = z_q;
                2'd2: x_d = mem_rdata;
                2'd3: x_d = g_q;
            endcase
        end
        if (y_wr) y_d = y_src;

        // Sticky: only an overflowing result that actually lands in A or Z counts.
        if (alu_ovf && ((a_wr && a_mux == 2'd1) || (z_wr && z_mux == 2'd1)))
            ovf_d = 1'b1;
    end

    // State registers; reset aborts any in-flight update and re-points Z at the fetch vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            g_q   <= '0;
            lp_q  <= '0;
            q_q   <= '0;
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= {{(DATA_W-ADDR_W){1'b0}}, RESET_VEC};
            ext_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            g_q   <= g_d;
            lp_q  <= lp_d;
            q_q   <= q_d;
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
            ext_q <= ext_flag;
            ovf_q <= ovf_d;
        end
    end

    assign mem_addr  = maddr_mux ? b_q[ADDR_W-1:0] : z_q[ADDR_W-1:0];
    assign mem_wdata = mdata_mux ? g_q : a_q;
    assign mem_we    = mem_wr;
    assign opcode    = b_q[DATA_W-1 -: 3];
    assign qc        = b_q[DATA_W-4 -: 2];
    assign extracode = ext_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_agc_datapath.sv
// tb_agc_datapath: directed vectors for the datapath; memory read data is driven
// straight from the bench, expected values are worked out by hand.
module tb_agc_datapath;

    logic        clk;
    logic        rst_n;
    logic        mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr;
    logic        maddr_mux, mdata_mux, lp_mux, g_mux, b_mux;
    logic [1:0]  q_mux, a_mux, x_mux, z_mux;
    logic [2:0]  alu_op, y_mux;
    logic        ext_flag;
    logic [14:0] mem_rdata;
    logic [11:0] mem_addr;
    logic [14:0] mem_wdata;
    logic        mem_we;
    logic [2:0]  opcode;
    logic [1:0]  qc;
    logic        extracode;
    logic [14:0] a_q, z_q;
    logic        ovf;

    int n_chk = 0;
    int n_bad = 0;

    agc_datapath #(.DATA_W(15), .ADDR_W(12), .RESET_VEC(12'h800)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_wr(mem_wr), .lp_wr(lp_wr), .g_wr(g_wr), .q_wr(q_wr), .b_wr(b_wr),
        .a_wr(a_wr), .y_wr(y_wr), .x_wr(x_wr), .z_wr(z_wr),
        .maddr_mux(maddr_mux), .mdata_mux(mdata_mux), .lp_mux(lp_mux),
        .g_mux(g_mux), .b_mux(b_mux),
        .q_mux(q_mux), .a_mux(a_mux), .x_mux(x_mux), .z_mux(z_mux),
        .alu_op(alu_op), .y_mux(y_mux), .ext_flag(ext_flag),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .opcode(opcode), .qc(qc), .extracode(extracode),
        .a_q(a_q), .z_q(z_q), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'o%0o expected 'o%0o", tag, got, exp);
        end
    endtask

    task automatic idle();
        mem_wr = 0; lp_wr = 0; g_wr = 0; q_wr = 0; b_wr = 0;
        a_wr = 0; y_wr = 0; x_wr = 0; z_wr = 0;
        maddr_mux = 0; mdata_mux = 0; lp_mux = 0; g_mux = 0; b_mux = 0;
        q_mux = 0; a_mux = 0; x_mux = 0; z_mux = 0;
        alu_op = 0; y_mux = 0; ext_flag = 0;
    endtask

    // one clock edge, then sample 1 time unit later and drop all strobes
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load_x(input logic [14:0] v);
        mem_rdata = v; x_mux = 2'd2; x_wr = 1; step();
    endtask

    task automatic load_y(input logic [14:0] v);
        mem_rdata = v; y_mux = 3'd1; y_wr = 1; step();
    endtask

    task automatic alu_to_a(input logic [2:0] op);
        alu_op = op; a_mux = 2'd1; a_wr = 1; step();
    endtask

    logic [14:0] ccs_in  [4] = '{15'd5, 15'd0, 15'o77000, 15'o77777};
    logic [14:0] ccs_exp [4] = '{15'd0, 15'd1, 15'd2,     15'd3};
    logic [14:0] mm1_in  [4] = '{15'o77772, 15'o77777, 15'd0, 15'd10};
    logic [14:0] mm1_exp [4] = '{15'd4,     15'd0,     15'd0, 15'd9};

    initial begin
        idle();
        rst_n     = 1'b0;
        mem_rdata = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_z", 32'(z_q), 'h800);
        chk("rst_a", 32'(a_q), 0);
        chk("rst_opcode", 32'(opcode), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_addr", 32'(mem_addr), 'h800);
        rst_n = 1'b1;
        step(); step();
        chk("idle_z", 32'(z_q), 'h800);
        chk("idle_a", 32'(a_q), 0);

        // extend flag lags one cycle into extracode
        ext_flag = 1; step();
        chk("ext_set", 32'(extracode), 1);
        step();
        chk("ext_clr", 32'(extracode), 0);

        // fetch into B
        mem_rdata = 15'o13456; b_mux = 0; b_wr = 1; step();
        chk("fetch1_op", 32'(opcode), 1);
        chk("fetch1_qc", 32'(qc), 1);
        mem_rdata = 15'o60123; b_mux = 0; b_wr = 1; #1;
        chk("fetch_addr_z", 32'(mem_addr), 'h800);
        step();
        chk("fetch_op", 32'(opcode), 6);
        chk("fetch_qc", 32'(qc), 0);
        maddr_mux = 1; #1;
        chk("baddr", 32'(mem_addr), 'o123);
        maddr_mux = 0;

        // add, overflow only when landing in A
        load_x(15'd5); load_y(15'd3); alu_to_a(3'd0);
        chk("ad_5_3", 32'(a_q), 'o10);
        chk("ad_no_ovf", 32'(ovf), 0);
        load_x(15'o37777); load_y(15'd1);
        alu_op = 0; g_mux = 1; g_wr = 1; step();
        mdata_mux = 1; #1;
        chk("ad_to_g", 32'(mem_wdata), 'o40000);
        chk("ovf_g_only", 32'(ovf), 0);
        mdata_mux = 0;
        alu_to_a(3'd0);
        chk("ad_ovf_a", 32'(a_q), 'o40000);
        chk("ovf_set", 32'(ovf), 1);

        // end-around carry and negative zero
        load_x(15'o77776); load_y(15'd2); alu_to_a(3'd0);
        chk("ad_eac", 32'(a_q), 1);
        load_x(15'd5); load_y(15'd5); alu_to_a(3'd1);
        chk("su_negzero", 32'(a_q), 'o77777);
        chk("ovf_sticky", 32'(ovf), 1);

        // simultaneous writes read old values
        mem_rdata = 15'd7; a_mux = 0; a_wr = 1; step();
        mem_rdata = 15'd9; g_mux = 0; g_wr = 1; step();
        x_mux = 0; x_wr = 1; y_mux = 0; y_wr = 1; step();
        a_mux = 2'd3; a_wr = 1; g_mux = 1; g_wr = 1; alu_op = 0; step();
        chk("swap_a", 32'(a_q), 9);
        mdata_mux = 1; #1;
        chk("swap_g", 32'(mem_wdata), 7);
        mdata_mux = 0;
        a_mux = 2'd2; a_wr = 1; step();
        chk("a_notg", 32'(a_q), 'o77770);
        mem_wr = 1; #1;
        chk("mem_we", 32'(mem_we), 1);
        chk("mem_wdata_a", 32'(mem_wdata), 'o77770);
        step();
        chk("mem_we_off", 32'(mem_we), 0);

        // multiply
        load_x(15'd300); load_y(15'd200);
        alu_to_a(3'd3); chk("mp0", 32'(a_q), 27232);
        alu_to_a(3'd4); chk("mp1", 32'(a_q), 1);
        load_x(15'd32467);
        alu_to_a(3'd3); chk("mp0_neg", 32'(a_q), 5535);
        alu_to_a(3'd4); chk("mp1_neg", 32'(a_q), 32766);

        // divide
        load_x(15'd17); load_y(15'd5);
        alu_to_a(3'd6); chk("dv_quo", 32'(a_q), 3);
        alu_to_a(3'd5); chk("dv_rem", 32'(a_q), 2);
        load_y(15'd0);
        alu_to_a(3'd6); chk("dv0_quo", 32'(a_q), 'o37777);
        alu_to_a(3'd5); chk("dv0_rem", 32'(a_q), 17);
        load_y(15'o77777);
        alu_to_a(3'd6); chk("dvm0_quo", 32'(a_q), 'o37777);

        // mask and unused code
        load_x(15'o70707); load_y(15'o07777);
        alu_to_a(3'd2); chk("mask", 32'(a_q), 'o707);
        alu_to_a(3'd7); chk("op7", 32'(a_q), 0);

        // Y sources
        load_x(15'd5); y_mux = 3'd2; y_wr = 1; step();
        alu_to_a(3'd0); chk("y_plus1", 32'(a_q), 6);
        load_x(15'd0);
        for (int i = 0; i < 4; i++) begin
            mem_rdata = ccs_in[i]; y_mux = 3'd3; y_wr = 1; step();
            alu_to_a(3'd0);
            chk($sformatf("ccs%0d", i), 32'(a_q), 32'(ccs_exp[i]));
        end
        for (int i = 0; i < 4; i++) begin
            mem_rdata = mm1_in[i]; y_mux = 3'd4; y_wr = 1; step();
            alu_to_a(3'd0);
            chk($sformatf("magm1_%0d", i), 32'(a_q), 32'(mm1_exp[i]));
        end

        // Z from B address field, then from A
        z_mux = 2'd2; z_wr = 1; step();
        chk("z_baddr", 32'(z_q), 'o123);
        chk("z_memaddr", 32'(mem_addr), 'o123);
        z_mux = 2'd3; z_wr = 1; step();
        chk("z_from_a", 32'(z_q), 9);

        // asynchronous reset mid-instruction
        mem_rdata = 15'o1234; a_mux = 0; a_wr = 1; #2;
        rst_n = 1'b0; #1;
        chk("arst_z", 32'(z_q), 'h800);
        chk("arst_a", 32'(a_q), 0);
        chk("arst_ovf", 32'(ovf), 0);
        chk("arst_op", 32'(opcode), 0);
        @(posedge clk); #1;
        chk("arst_hold_a", 32'(a_q), 0);
        idle();
        rst_n = 1'b1;
        step();
        chk("post_rst_z", 32'(z_q), 'h800);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
